// File: rtl/act_layer_seq.sv
// act_layer_seq: layer sequencer for the accumulate/activation/FC datapath.
// Holds a host-written descriptor table, loads one layer's configuration at a
// time, pulses the conv or FC start, and waits for the activation act_last
// lanes before advancing to the next layer.
// Optional per-layer watchdog: define SEQ_TIMEOUT_EN.
module act_layer_seq #(
    parameter int unsigned NUM_LAYERS     = 8,
    parameter int unsigned ACC_NUM        = 16,
    parameter int unsigned FA_NUM         = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_wren_i,
    input  logic [$clog2(NUM_LAYERS)-1:0] cfg_addr_i,
    input  logic [27:0]                   cfg_wdata_i,
    input  logic [$clog2(NUM_LAYERS):0]   num_layers_i,
    input  logic                          start_i,
    input  logic                          act_last_i [ACC_NUM+FA_NUM],
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(NUM_LAYERS)-1:0] layer_idx_o,
    output logic                          conv_start_o,
    output logic                          start_fc_o,
    output logic [4:0]                    ofmap_size_o,
    output logic [5:0]                    ifmap_ch_o,
    output logic [8:0]                    in_node_num_o,
    output logic [6:0]                    out_node_num_o,
    output logic [1:0]                    nth_fully_o,
    output logic                          err_o
);

    localparam int unsigned IW = $clog2(NUM_LAYERS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ADV   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [27:0]        table_q [NUM_LAYERS];
    logic [2:0]         state_q, state_d;
    logic [IW:0]        count_q, count_d;
    logic [IW-1:0]      layer_idx_q, layer_idx_d;
    logic [1:0]         nth_fully_q, nth_fully_d;
    logic               cur_fc_q, cur_fc_d;
    logic [ACC_NUM-1:0] sticky_q, sticky_d;
    logic [4:0]         ofmap_size_q, ofmap_size_d;
    logic [5:0]         ifmap_ch_q, ifmap_ch_d;
    logic [8:0]         in_node_num_q, in_node_num_d;
    logic [6:0]         out_node_num_q, out_node_num_d;

    logic [ACC_NUM-1:0] conv_last;
    logic [ACC_NUM-1:0] lanes_seen;
    logic               fc_last;
    logic               layer_done;
    logic [27:0]        desc;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    // Host descriptor writes, accepted only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (cfg_wren_i && state_q == S_IDLE) begin
            table_q[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    // Split the activation last lanes into the conv group and the FC lane.
    always_comb begin
        conv_last = '0;
        for (int unsigned i = 0; i < ACC_NUM; i++) begin
            conv_last[i] = act_last_i[i];
        end
        fc_last    = act_last_i[ACC_NUM];
        lanes_seen = sticky_q | conv_last;
        layer_done = cur_fc_q ? fc_last : &lanes_seen;
        desc       = table_q[layer_idx_q];
    end

    // Sequencer next-state and configuration update.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        layer_idx_d    = layer_idx_q;
        nth_fully_d    = nth_fully_q;
        cur_fc_d       = cur_fc_q;
        sticky_d       = sticky_q;
        ofmap_size_d   = ofmap_size_q;
        ifmap_ch_d     = ifmap_ch_q;
        in_node_num_d  = in_node_num_q;
        out_node_num_d = out_node_num_q;
`ifdef SEQ_TIMEOUT_EN
        cnt_d          = cnt_q;
        err_d          = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d     = num_layers_i;
                    layer_idx_d = '0;
                    nth_fully_d = '0;
                    sticky_d    = '0;
`ifdef SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = (num_layers_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                cur_fc_d = desc[27];
                if (desc[27]) begin
                    in_node_num_d  = desc[15:7];
                    out_node_num_d = desc[6:0];
                end else begin
                    ofmap_size_d = desc[26:22];
                    ifmap_ch_d   = desc[21:16];
                end
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                sticky_d = '0;
`ifdef SEQ_TIMEOUT_EN
                cnt_d    = '0;
`endif
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (!cur_fc_q) begin
                    sticky_d = lanes_seen;
                end
                if (layer_done) state_d = S_ADV;
`ifdef SEQ_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_ADV: begin
                if (cur_fc_q && nth_fully_q != 2'd3) begin
                    nth_fully_d = nth_fully_q + 2'd1;
                end
                if ({1'b0, layer_idx_q} == count_q - (IW+1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    layer_idx_d = layer_idx_q + IW'(1);
                    state_d     = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and configuration registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            layer_idx_q    <= '0;
            nth_fully_q    <= '0;
            cur_fc_q       <= 1'b0;
            sticky_q       <= '0;
            ofmap_size_q   <= '0;
            ifmap_ch_q     <= '0;
            in_node_num_q  <= '0;
            out_node_num_q <= '0;
`ifdef SEQ_TIMEOUT_EN
            cnt_q          <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            layer_idx_q    <= layer_idx_d;
            nth_fully_q    <= nth_fully_d;
            cur_fc_q       <= cur_fc_d;
            sticky_q       <= sticky_d;
            ofmap_size_q   <= ofmap_size_d;
            ifmap_ch_q     <= ifmap_ch_d;
            in_node_num_q  <= in_node_num_d;
            out_node_num_q <= out_node_num_d;
`ifdef SEQ_TIMEOUT_EN
            cnt_q          <= cnt_d;
            err_q          <= err_d;
`endif
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign conv_start_o   = (state_q == S_ISSUE) && !cur_fc_q;
    assign start_fc_o     = (state_q == S_ISSUE) && cur_fc_q;
    assign layer_idx_o    = layer_idx_q;
    assign ofmap_size_o   = ofmap_size_q;
    assign ifmap_ch_o     = ifmap_ch_q;
    assign in_node_num_o  = in_node_num_q;
    assign out_node_num_o = out_node_num_q;
    assign nth_fully_o    = nth_fully_q;
`ifdef SEQ_TIMEOUT_EN
    assign err_o          = err_q;
`else
    // Without the watchdog the limit has no effect and err_o is constant 0.
    assign err_o          = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule
